ram_vector_sum: RTL and testbench

Accelerator kernel that reads a contiguous run of words from the shared single-port-pair `RAM`, sums them, and writes the sum back to a destination address in the same `RAM`. It sits directly downstream of `read_add_2_ram` on the same `RAM` instance and uses the identical start/ready/done handshake and `ram_*_0` port group. A top-level sequencer therefore chains it after that kernel, for example summing a block that contains the word `read_add_2_ram` produced.

---
 rtl/cac_kernel_pkg.sv | 13 +
 rtl/ram_vector_sum.sv | 107 ++++++++++
 tb/tb_ram_vector_sum.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cac_kernel_pkg.sv
// Shared constants for the RAM accelerator kernels: default widths and FSM state encodings.
package cac_kernel_pkg;

    localparam int unsigned DefWidth     = 32;
    localparam int unsigned DefAddrWidth = 32;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/ram_vector_sum.sv
// Sums len consecutive RAM words starting at src_addr and writes the result to dst_addr.
module ram_vector_sum
    import cac_kernel_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [ADDR_WIDTH-1:0] ram_raddr_0,
    input  logic [WIDTH-1:0]      ram_rdata_0,
    output logic [ADDR_WIDTH-1:0] ram_waddr_0,
    output logic                  ram_wen_0,
    output logic [WIDTH-1:0]      ram_wdata_0
);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_issued;
    logic                  r_acc_en;
    logic [WIDTH-1:0]      r_acc;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_wen;
    logic [WIDTH-1:0]      r_wdata;
    logic [WIDTH-1:0]      w_sum;

    assign w_sum = r_acc + ram_rdata_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_len    <= '0;
            r_dst    <= '0;
            r_issued <= '0;
            r_acc_en <= 1'b0;
            r_acc    <= '0;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_len    <= len;
                        r_dst    <= dst_addr;
                        r_acc    <= '0;
                        r_acc_en <= 1'b0;
                        if (len != '0) begin
                            r_raddr  <= src_addr;
                            r_issued <= ADDR_WIDTH'(1);
                            r_state  <= StRead;
                        end else begin
                            r_wdata <= '0;
                            r_waddr <= dst_addr;
                            r_wen   <= 1'b1;
                            r_state <= StWrite;
                        end
                    end
                end
                StRead: begin
                    // Read data trails the address by one cycle, so skip the first READ cycle.
                    if (r_acc_en) begin
                        r_acc <= w_sum;
                    end
                    r_acc_en <= 1'b1;
                    if (r_issued == r_len) begin
                        r_state <= StDrain;
                    end else begin
                        r_raddr  <= r_raddr + ADDR_WIDTH'(1);
                        r_issued <= r_issued + ADDR_WIDTH'(1);
                    end
                end
                StDrain: begin
                    r_acc   <= w_sum;
                    r_wdata <= w_sum;
                    r_waddr <= r_dst;
                    r_wen   <= 1'b1;
                    r_state <= StWrite;
                end
                StWrite: begin
                    r_wen   <= 1'b0;
                    r_state <= StDone;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ready       = (r_state == StIdle) || (r_state == StDone);
    assign done        = (r_state == StDone);
    assign ram_raddr_0 = r_raddr;
    assign ram_waddr_0 = r_waddr;
    assign ram_wen_0   = r_wen;
    assign ram_wdata_0 = r_wdata;

endmodule

// File: tb/tb_ram_vector_sum.sv
// Directed bench for ram_vector_sum against a small 1-cycle-latency RAM model.
module tb_ram_vector_sum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic        done;
    logic [31:0] src_addr;
    logic [31:0] len;
    logic [31:0] dst_addr;
    logic [31:0] ram_raddr_0;
    logic [31:0] ram_rdata_0;
    logic [31:0] ram_waddr_0;
    logic        ram_wen_0;
    logic [31:0] ram_wdata_0;

    logic [31:0] mem [0:63];
    int          checks   = 0;
    int          failures = 0;
    int          pulses;

    always #5 clk = ~clk;

    ram_vector_sum dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .done        (done),
        .src_addr    (src_addr),
        .len         (len),
        .dst_addr    (dst_addr),
        .ram_raddr_0 (ram_raddr_0),
        .ram_rdata_0 (ram_rdata_0),
        .ram_waddr_0 (ram_waddr_0),
        .ram_wen_0   (ram_wen_0),
        .ram_wdata_0 (ram_wdata_0)
    );

    // Read-before-write RAM model; the bench preloads and inspects mem directly.
    always @(posedge clk) begin
        ram_rdata_0 <= mem[ram_raddr_0[5:0]];
        if (ram_wen_0) mem[ram_waddr_0[5:0]] = ram_wdata_0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] l, input logic [31:0] d);
        start    = 1'b1;
        src_addr = s;
        len      = l;
        dst_addr = d;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; len = '0; dst_addr = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wen", {31'd0, ram_wen_0}, 32'd0);
        check("rst_raddr", ram_raddr_0, 32'd0);
        check("rst_waddr", ram_waddr_0, 32'd0);
        check("rst_wdata", ram_wdata_0, 32'd0);
        rst = 1'b0;

        // Basic 4-word sum: 17+1+2+3 = 23 to [20]; inputs scrambled after capture.
        mem[12] = 32'd17; mem[13] = 32'd1; mem[14] = 32'd2; mem[15] = 32'd3;
        go(32'd12, 32'd4, 32'd20);
        tick();                                             // E0
        check("t1_ready_e0", {31'd0, ready}, 32'd0);
        check("t1_raddr_e0", ram_raddr_0, 32'd12);
        start = 1'b0; src_addr = 32'd40; len = 32'd7; dst_addr = 32'd41;
        tick(); tick(); tick();                             // E3
        check("t1_raddr_last", ram_raddr_0, 32'd15);
        tick();                                             // E4
        check("t1_wen_e4", {31'd0, ram_wen_0}, 32'd0);
        tick();                                             // E5
        check("t1_wen_e5", {31'd0, ram_wen_0}, 32'd1);
        check("t1_waddr", ram_waddr_0, 32'd20);
        check("t1_wdata", ram_wdata_0, 32'd23);
        check("t1_done_e5", {31'd0, done}, 32'd0);
        tick();                                             // E6
        check("t1_done_e6", {31'd0, done}, 32'd1);
        check("t1_ready_e6", {31'd0, ready}, 32'd1);
        check("t1_wen_e6", {31'd0, ram_wen_0}, 32'd0);
        check("t1_mem20", mem[20], 32'd23);
        check("t1_mem41", mem[41], 32'd0);

        // len = 0 writes zero to [21].
        mem[21] = 32'd9;
        go(32'd0, 32'd0, 32'd21);
        tick();                                             // E0
        check("t2_wen_e0", {31'd0, ram_wen_0}, 32'd1);
        check("t2_ready_e0", {31'd0, ready}, 32'd0);
        check("t2_done_e0", {31'd0, done}, 32'd0);
        start = 1'b0;
        tick();                                             // E1
        check("t2_done_e1", {31'd0, done}, 32'd1);
        check("t2_mem21", mem[21], 32'd0);

        // Sum overflow with destination overlapping the source range.
        mem[30] = 32'hFFFF_FFFF; mem[31] = 32'd2;
        go(32'd30, 32'd2, 32'd31);
        tick();
        start = 1'b0;
        tick(); tick(); tick();                             // E3
        check("t3_wen_e3", {31'd0, ram_wen_0}, 32'd1);
        check("t3_wdata", ram_wdata_0, 32'd1);
        tick();                                             // E4
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_mem31", mem[31], 32'd1);

        // start held high: one job through E4, then re-accepted from DONE at E5.
        mem[22] = 32'd0;
        go(32'd12, 32'd2, 32'd22);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ram_wen_0) pulses++;
        end
        check("t4_pulses", pulses, 32'd1);
        check("t4_done_e4", {31'd0, done}, 32'd1);
        check("t4_mem22", mem[22], 32'd18);
        tick();                                             // E5
        check("t4_done_e5", {31'd0, done}, 32'd0);
        check("t4_ready_e5", {31'd0, ready}, 32'd0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_done_again", {31'd0, done}, 32'd1);

        // Reset two edges into a job: destination keeps its old value.
        mem[24] = 32'd5;
        go(32'd12, 32'd4, 32'd24);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t5_ready", {31'd0, ready}, 32'd1);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_wen", {31'd0, ram_wen_0}, 32'd0);
        check("t5_raddr", ram_raddr_0, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ram_wen_0) pulses++;
        end
        check("t5_no_write", pulses, 32'd0);
        check("t5_mem24", mem[24], 32'd5);
        check("t5_idle_done", {31'd0, done}, 32'd0);

        // rst and start on the same edge: rst wins, no job starts.
        rst = 1'b1;
        go(32'd12, 32'd1, 32'd25);
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check("t6_ready", {31'd0, ready}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_wen", {31'd0, ram_wen_0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
